// File: rtl/alu_input_sequencer.sv
// rtl/alu_input_sequencer.sv - debounced key/switch front end issuing one req/ack ALU transaction per execute press
module alu_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [3:0]  key_n,
    input  logic [16:0] sw,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [3:0]  op_out,
    output logic        req,
    input  logic        ack,
    input  logic [31:0] result_in,
    input  logic [2:0]  flags_in,
    output logic [31:0] result_q,
    output logic [2:0]  flags_q,
    output logic        res_valid,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state, state_next;
    logic [3:0]    key_s1, key_s2, key_db, key_db_next, press, sel;
    logic [CW-1:0] cnt [4];
    logic [16:0]   sw_s1, sw_s2;
    logic [31:0]   sw_ext;
    logic          load_a, load_b, load_op, capture, clear_valid;

    // Level flips on the edge where the Nth consecutive differing sample is seen.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            key_db_next[i] = key_db[i];
            if (key_s2[i] != key_db[i] && cnt[i] == CNT_LAST)
                key_db_next[i] = key_s2[i];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            key_db <= 4'hF;
            press  <= 4'h0;
            sw_s1  <= '0;
            sw_s2  <= '0;
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            key_db <= key_db_next;
            press  <= key_db & ~key_db_next;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == key_db[i] || key_db_next[i] != key_db[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Isolate the lowest-numbered press; the rest are dropped.
    assign sel    = press & (~press + 4'd1);
    assign sw_ext = {{16{sw_s2[16]}}, sw_s2[15:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_op     = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE, DONE: begin
                load_a      = sel[0];
                load_b      = sel[1];
                load_op     = sel[2];
                clear_valid = |sel;
                if (sel[3])
                    state_next = ISSUE;
                else if (|sel[2:0])
                    state_next = IDLE;
            end
            ISSUE: begin
                if (ack) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            res_valid <= 1'b0;
        end else begin
            if (load_a)
                a_out <= sw_ext;
            if (load_b)
                b_out <= sw_ext;
            if (load_op)
                op_out <= sw_s2[3:0];
            if (capture) begin
                result_q  <= result_in;
                flags_q   <= flags_in;
                res_valid <= 1'b1;
            end else if (clear_valid) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign req  = (state == ISSUE);
    assign busy = (state == ISSUE);

endmodule
